// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC redirect and stall in, instruction memory port, decoded fields out.
interface fetch_stage_if;
    logic [63:0] PC_new;
    logic        pc_load;
    logic        stall;
    logic [63:0] imem_addr;
    logic [79:0] imem_rdata;
    logic        imem_err;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_valid;
    logic [2:0]  stat;

    // Fetch stage side
    modport master (
        input  PC_new, pc_load, stall, imem_rdata, imem_err,
        output imem_addr, icode, ifun, rA, rB, valC, valP, instr_valid, stat
    );

    // Consumer / memory side
    modport slave (
        output PC_new, pc_load, stall, imem_rdata, imem_err,
        input  imem_addr, icode, ifun, rA, rB, valC, valP, instr_valid, stat
    );
endinterface

// File: rtl/fetch_stage.sv
// Y86-64 style fetch stage: holds the PC, decodes the 10-byte window at the PC and
// registers the decoded fields; stops permanently on halt, bad address or bad encoding.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic           clk,
    input logic           rst_n,
    fetch_stage_if.master bus
);
    localparam int unsigned XLEN   = 64;
    localparam int unsigned NIBBLE = 4;
    localparam int unsigned STATW  = 3;

    localparam logic [STATW-1:0] STAT_AOK = 3'd1;
    localparam logic [STATW-1:0] STAT_HLT = 3'd2;
    localparam logic [STATW-1:0] STAT_ADR = 3'd3;
    localparam logic [STATW-1:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

    state_t state, state_nx;

    logic [XLEN-1:0]   pc, pc_nx;
    logic [NIBBLE-1:0] icode_q, icode_nx, ifun_q, ifun_nx;
    logic [NIBBLE-1:0] ra_q, ra_nx, rb_q, rb_nx;
    logic [XLEN-1:0]   valc_q, valc_nx, valp_q, valp_nx;
    logic              valid_q, valid_nx;
    logic [STATW-1:0]  stat_q, stat_nx;

    logic [7:0]        byte0, byte1;
    logic [NIBBLE-1:0] d_icode, d_ifun;
    logic              need_regids, need_valc, invalid;
    logic [XLEN-1:0]   d_valc, d_valp;

    assign bus.imem_addr   = pc;
    assign bus.icode       = icode_q;
    assign bus.ifun        = ifun_q;
    assign bus.rA          = ra_q;
    assign bus.rB          = rb_q;
    assign bus.valC        = valc_q;
    assign bus.valP        = valp_q;
    assign bus.instr_valid = valid_q;
    assign bus.stat        = stat_q;

    // Decode the instruction window at the current PC
    always_comb begin
        byte0       = bus.imem_rdata[7:0];
        byte1       = bus.imem_rdata[15:8];
        d_icode     = byte0[7:4];
        d_ifun      = byte0[3:0];
        need_regids = 1'b0;
        need_valc   = 1'b0;
        invalid     = 1'b0;
        case (d_icode)
            4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            4'h7, 4'h8: need_valc = 1'b1;
            default: ;
        endcase
        case (d_icode)
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: invalid = (d_ifun != 4'h0);
            4'h2, 4'h7: invalid = (d_ifun > 4'h6);
            4'h6:       invalid = (d_ifun > 4'h3);
            default:    invalid = 1'b1;
        endcase
        d_valc = '0;
        if (need_valc) begin
            d_valc = need_regids ? bus.imem_rdata[79:16] : bus.imem_rdata[71:8];
        end
        // Fall-through PC wraps modulo 2^64 by construction
        d_valp = pc + 64'd1 + XLEN'(need_regids) + (need_valc ? 64'd8 : 64'd0);
    end

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            pc      <= RESET_PC;
            icode_q <= '0;
            ifun_q  <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            valc_q  <= '0;
            valp_q  <= '0;
            valid_q <= 1'b0;
            stat_q  <= STAT_AOK;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            icode_q <= icode_nx;
            ifun_q  <= ifun_nx;
            ra_q    <= ra_nx;
            rb_q    <= rb_nx;
            valc_q  <= valc_nx;
            valp_q  <= valp_nx;
            valid_q <= valid_nx;
            stat_q  <= stat_nx;
        end
    end

    // Next-state and next-output logic; HALTED and FAULT hold everything
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        icode_nx = icode_q;
        ifun_nx  = ifun_q;
        ra_nx    = ra_q;
        rb_nx    = rb_q;
        valc_nx  = valc_q;
        valp_nx  = valp_q;
        valid_nx = 1'b0;
        stat_nx  = stat_q;
        case (state)
            RUN: begin
                if (bus.pc_load) begin
                    pc_nx = bus.PC_new;
                end
                if (!bus.stall) begin
                    valid_nx = 1'b1;
                    icode_nx = d_icode;
                    ifun_nx  = d_ifun;
                    ra_nx    = need_regids ? byte1[7:4] : 4'hF;
                    rb_nx    = need_regids ? byte1[3:0] : 4'hF;
                    valc_nx  = d_valc;
                    valp_nx  = d_valp;
                    if (bus.imem_err) begin
                        // Bad address: report as a nop so nothing downstream acts on garbage
                        icode_nx = 4'h1;
                        ifun_nx  = 4'h0;
                        ra_nx    = 4'hF;
                        rb_nx    = 4'hF;
                        valc_nx  = '0;
                        valp_nx  = pc + 64'd1;
                        stat_nx  = STAT_ADR;
                        state_nx = FAULT;
                    end else if (invalid) begin
                        stat_nx  = STAT_INS;
                        state_nx = FAULT;
                    end else if (d_icode == 4'h0) begin
                        stat_nx  = STAT_HLT;
                        state_nx = HALTED;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized run against a table-driven model.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instruction length and highest legal ifun per icode; -1 means icode itself is illegal
    int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    int max_fun [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};

    // Model state
    logic [63:0] m_pc;
    int          m_mode;   // 0 run, 1 halted, 2 fault
    int          m_idle;
    logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
    logic [63:0] e_valc, e_valp;
    logic        e_valid;
    logic [2:0]  e_stat;
    logic        dc;       // after an address fault only icode/ifun are defined

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.stall = 1'b1;
        bus.pc_load = 1'b0;
        bus.imem_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_mode = 0; m_idle = 0;
        e_icode = 0; e_ifun = 0; e_ra = 0; e_rb = 0;
        e_valc = 0; e_valp = 0; e_valid = 0; e_stat = 3'd1; dc = 1'b0;
    endtask

    task automatic check_all(input string pfx);
        check_eq({pfx, "_addr"},  bus.imem_addr, m_pc);
        check_eq({pfx, "_icode"}, 64'(bus.icode), 64'(e_icode));
        check_eq({pfx, "_ifun"},  64'(bus.ifun), 64'(e_ifun));
        check_eq({pfx, "_valid"}, 64'(bus.instr_valid), 64'(e_valid));
        check_eq({pfx, "_stat"},  64'(bus.stat), 64'(e_stat));
        if (!dc) begin
            check_eq({pfx, "_rA"},   64'(bus.rA), 64'(e_ra));
            check_eq({pfx, "_rB"},   64'(bus.rB), 64'(e_rb));
            check_eq({pfx, "_valC"}, bus.valC, e_valc);
            check_eq({pfx, "_valP"}, bus.valP, e_valp);
        end
    endtask

    initial begin
        logic [7:0] b [10];
        logic [3:0] ic, fn;
        logic       st, ld, er;
        logic [63:0] pcn;
        int r, len, off, pick;

        rst_n = 1'b0;
        bus.stall = 1'b1;
        bus.pc_load = 1'b0;
        bus.PC_new = '0;
        bus.imem_err = 1'b0;
        bus.imem_rdata = '0;
        #12;
        check_eq("rst_addr",  bus.imem_addr, 64'h0);
        check_eq("rst_icode", 64'(bus.icode), 64'h0);
        check_eq("rst_rA",    64'(bus.rA), 64'h0);
        check_eq("rst_valC",  bus.valC, 64'h0);
        check_eq("rst_valP",  bus.valP, 64'h0);
        check_eq("rst_valid", 64'(bus.instr_valid), 64'h0);
        check_eq("rst_stat",  64'(bus.stat), 64'h1);

        // irmovq with constant at PC 0
        @(negedge clk);
        rst_n = 1'b1;
        bus.stall = 1'b0;
        bus.imem_rdata = {64'h0123456789ABCDEF, 8'hF3, 8'h30};
        cycle();
        check_eq("irm_icode", 64'(bus.icode), 64'h3);
        check_eq("irm_ifun",  64'(bus.ifun), 64'h0);
        check_eq("irm_rA",    64'(bus.rA), 64'hF);
        check_eq("irm_rB",    64'(bus.rB), 64'h3);
        check_eq("irm_valC",  bus.valC, 64'h0123456789ABCDEF);
        check_eq("irm_valP",  bus.valP, 64'h0A);
        check_eq("irm_valid", 64'(bus.instr_valid), 64'h1);
        check_eq("irm_stat",  64'(bus.stat), 64'h1);

        // call at 0x100 with simultaneous redirect to 0x200
        @(negedge clk);
        bus.stall = 1'b1; bus.pc_load = 1'b1; bus.PC_new = 64'h100;
        cycle();
        check_eq("ld_addr",  bus.imem_addr, 64'h100);
        check_eq("ld_valid", 64'(bus.instr_valid), 64'h0);
        @(negedge clk);
        bus.stall = 1'b0; bus.pc_load = 1'b1; bus.PC_new = 64'h200;
        bus.imem_rdata = {8'h00, 64'h200, 8'h80};
        cycle();
        check_eq("call_icode", 64'(bus.icode), 64'h8);
        check_eq("call_rA",    64'(bus.rA), 64'hF);
        check_eq("call_valP",  bus.valP, 64'h109);
        check_eq("call_valC",  bus.valC, 64'h200);
        check_eq("call_addr",  bus.imem_addr, 64'h200);

        // stall freezes outputs while pc_load still redirects
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.stall = 1'b1; bus.pc_load = 1'b1; bus.PC_new = 64'h40;
            bus.imem_rdata = {$urandom(), $urandom(), $urandom()};
            cycle();
            check_eq("stl_valid", 64'(bus.instr_valid), 64'h0);
            check_eq("stl_icode", 64'(bus.icode), 64'h8);
            check_eq("stl_valC",  bus.valC, 64'h200);
            check_eq("stl_valP",  bus.valP, 64'h109);
            check_eq("stl_addr",  bus.imem_addr, 64'h40);
        end

        // halt at 0x20, then redirect attempts are ignored
        @(negedge clk);
        bus.stall = 1'b1; bus.pc_load = 1'b1; bus.PC_new = 64'h20;
        cycle();
        @(negedge clk);
        bus.stall = 1'b0; bus.pc_load = 1'b0; bus.imem_rdata = '0;
        cycle();
        check_eq("hlt_valid", 64'(bus.instr_valid), 64'h1);
        check_eq("hlt_stat",  64'(bus.stat), 64'h2);
        check_eq("hlt_icode", 64'(bus.icode), 64'h0);
        check_eq("hlt_valP",  bus.valP, 64'h21);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.pc_load = 1'b1; bus.PC_new = 64'h80;
            cycle();
            check_eq("hld_valid", 64'(bus.instr_valid), 64'h0);
            check_eq("hld_addr",  bus.imem_addr, 64'h20);
            check_eq("hld_stat",  64'(bus.stat), 64'h2);
        end

        // bad encoding 0x6A
        do_reset();
        bus.stall = 1'b0; bus.imem_rdata = {64'h0, 8'h12, 8'h6A};
        cycle();
        check_eq("ins_stat",  64'(bus.stat), 64'h4);
        check_eq("ins_valid", 64'(bus.instr_valid), 64'h1);
        check_eq("ins_icode", 64'(bus.icode), 64'h6);
        cycle();
        check_eq("ins_hold_valid", 64'(bus.instr_valid), 64'h0);
        check_eq("ins_hold_stat",  64'(bus.stat), 64'h4);

        // address error beats a bad encoding
        do_reset();
        bus.stall = 1'b0; bus.imem_err = 1'b1; bus.imem_rdata = {64'h0, 8'h00, 8'hF0};
        cycle();
        check_eq("adr_stat",  64'(bus.stat), 64'h3);
        check_eq("adr_icode", 64'(bus.icode), 64'h1);
        check_eq("adr_ifun",  64'(bus.ifun), 64'h0);
        check_eq("adr_valid", 64'(bus.instr_valid), 64'h1);

        // valP wraps past 2^64-1, then asynchronous reset mid-cycle
        do_reset();
        bus.stall = 1'b1; bus.pc_load = 1'b1; bus.PC_new = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        @(negedge clk);
        bus.stall = 1'b0; bus.pc_load = 1'b0; bus.imem_rdata = {64'h5, 8'hF3, 8'h30};
        cycle();
        check_eq("wrap_valP", bus.valP, 64'h6);
        check_eq("wrap_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_addr",  bus.imem_addr, 64'h0);
        check_eq("arst_icode", 64'(bus.icode), 64'h0);
        check_eq("arst_rB",    64'(bus.rB), 64'h0);
        check_eq("arst_valC",  bus.valC, 64'h0);
        check_eq("arst_valP",  bus.valP, 64'h0);
        check_eq("arst_valid", 64'(bus.instr_valid), 64'h0);
        check_eq("arst_stat",  64'(bus.stat), 64'h1);

        // randomized run against the model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (m_mode != 0 && m_idle >= 3) begin
                do_reset();
                model_reset();
            end
            st  = ($urandom_range(0, 3) == 0);
            ld  = ($urandom_range(0, 2) == 0);
            er  = ($urandom_range(0, 39) == 0);
            pcn = {$urandom(), $urandom()};
            for (int k = 0; k < 10; k++) b[k] = 8'($urandom());
            r = $urandom_range(0, 99);
            if (r < 2) begin
                b[0] = 8'h00;
            end else if (r >= 8) begin
                pick = $urandom_range(1, 11);
                b[0] = {4'(pick), 4'($urandom_range(0, max_fun[pick]))};
            end
            bus.stall = st; bus.pc_load = ld; bus.PC_new = pcn; bus.imem_err = er;
            for (int k = 0; k < 10; k++) bus.imem_rdata[8*k +: 8] = b[k];

            if (m_mode == 0) begin
                if (!st) begin
                    e_valid = 1'b1;
                    if (er) begin
                        m_mode = 2; e_stat = 3'd3; e_icode = 4'h1; e_ifun = 4'h0; dc = 1'b1;
                    end else begin
                        ic = b[0][7:4];
                        fn = b[0][3:0];
                        len = len_tab[ic];
                        off = (len == 10) ? 2 : 1;
                        e_icode = ic;
                        e_ifun  = fn;
                        e_ra = (len == 2 || len == 10) ? b[1][7:4] : 4'hF;
                        e_rb = (len == 2 || len == 10) ? b[1][3:0] : 4'hF;
                        e_valc = '0;
                        if (len >= 9) begin
                            for (int k = 0; k < 8; k++) e_valc[8*k +: 8] = b[off + k];
                        end
                        e_valp = m_pc + 64'(len);
                        dc = 1'b0;
                        if (int'(fn) > max_fun[ic]) begin
                            m_mode = 2; e_stat = 3'd4;
                        end else if (ic == 4'h0) begin
                            m_mode = 1; e_stat = 3'd2;
                        end
                    end
                end else begin
                    e_valid = 1'b0;
                end
                if (ld) m_pc = pcn;
            end else begin
                e_valid = 1'b0;
                m_idle++;
            end

            cycle();
            check_all("rnd");
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port PC_new  input  64  next PC from the PC-update stage.
REQ-005 SHALL have port pc_load  input  1  when high, PC_new is captured into the PC register.
REQ-006 SHALL have port stall  input  1  when high, the decoded outputs are held.
REQ-007 SHALL have port imem_addr  output  64  current PC register, driven directly.
REQ-008 SHALL have port imem_rdata  input  80  combinational read of 10 bytes at imem_addr; byte k at [8k+7:8k].
REQ-009 SHALL have port imem_err  input  1  address invalid.
REQ-010 SHALL have ports icode, ifun, rA, rB  output  4 each  registered instruction fields.
REQ-011 SHALL have ports valC, valP  output  64 each  registered constant word and fall-through PC.
REQ-012 SHALL have port instr_valid  output  1  high for one cycle per newly fetched instruction.
REQ-013 SHALL have port stat  output  3  status: AOK=1, HLT=2, ADR=3, INS=4.

Function
REQ-014 SHALL decode byte0 as icode=[7:4] and ifun=[3:0].
REQ-015 SHALL set need_regids for icode 2,3,4,5,6,A,B; when set, rA=byte1[7:4] and rB=byte1[3:0]; otherwise rA=rB=4'hF.
REQ-016 SHALL set need_valC for icode 3,4,5,7,8; valC is little-endian from bytes 2..9 if need_regids is set, otherwise bytes 1..8; otherwise valC=0.
REQ-017 SHALL compute valP = PC + 1 + need_regids + 8*need_valC, modulo 2^64; a wrap past 2^64-1 is not an error.
REQ-018 SHALL treat as invalid: icode > B; ifun != 0 for icode 0,1,3,4,5,8,9,A,B; ifun > 6 for icode 2 or 7; ifun > 3 for icode 6.
REQ-019 SHALL use FSM states RUN, HALTED and FAULT.
REQ-020 In RUN with stall=0, SHALL register all decoded fields at the posedge and pulse instr_valid=1 for that cycle (latency 1 cycle from PC to outputs).
REQ-021 In RUN with stall=1, SHALL hold the decoded outputs and drive instr_valid=0.
REQ-022 In RUN, SHALL load PC <= PC_new when pc_load=1 and otherwise hold the PC.
REQ-023 pc_load SHALL be honoured even when stall=1.
REQ-024 In RUN with stall=0 and imem_err=1, SHALL go to FAULT with stat=ADR and instr_valid=1; the fields are registered as icode=1 (nop) and ifun=0.
REQ-025 In RUN with stall=0, no imem_err, and an invalid encoding, SHALL go to FAULT with stat=INS and instr_valid=1.
REQ-026 imem_err SHALL take priority over an invalid encoding.
REQ-027 In RUN with stall=0 and a valid icode 0 (halt), SHALL register the halt with instr_valid=1, go to HALTED and set stat=HLT.
REQ-028 In HALTED and FAULT, SHALL drive instr_valid=0, ignore pc_load, hold the PC, outputs and stat, and leave only on reset.

Reset
REQ-029 While rst_n=0 (asynchronous), SHALL set PC=RESET_PC, icode=ifun=rA=rB=0, valC=valP=0, instr_valid=0, stat=AOK and state=RUN.
REQ-030 A reset asserted mid-fetch SHALL discard the in-flight fetch.
REQ-031 The first fetch after release SHALL occur at the first posedge with rst_n=1 and stall=0.

Verification
REQ-032 Reset then imem_rdata byte0=30, byte1=F3, bytes2..9=0x0123456789ABCDEF LE -> next edge: icode=3, ifun=0, rA=F, rB=3, valC=0x0123456789ABCDEF, valP=0x0A, instr_valid=1, stat=1.
REQ-033 PC=0x100, byte0=0x80 (call) with dest 0x200, pc_load=1 with PC_new=0x200 -> valP=0x109, valC=0x200, imem_addr=0x200 next cycle.
REQ-034 stall=1 for 3 cycles while pc_load=1 with PC_new=0x40 -> outputs frozen, instr_valid=0, imem_addr=0x40.
REQ-035 byte0=0x00 at PC=0x20 -> instr_valid=1 once, stat=2; pc_load=1 with PC_new=0x80 is ignored and imem_addr stays 0x20.
REQ-036 byte0=0x6A -> stat=4; separately imem_err=1 together with byte0=0xF0 -> stat=3 (ADR wins).
REQ-037 PC=0xFFFFFFFFFFFFFFFC with irmovq -> valP=0x6; then rst_n=0 mid-cycle -> all outputs immediately take their reset values.
